// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RISC-V datapath (lw, sw, R, I-ALU, beq, jal).
// One state register; every output is decoded combinationally from state and the IR fields.
module multicycle_controller #(
  parameter bit ENABLE_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state_r;
  logic [3:0] state_nxt;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       ir_write_s;

  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_nxt;
  end

  assign state = state_r;

  always_comb begin
    state_nxt = S_FETCH;
    case (state_r)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = ENABLE_TRAP ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    branch      = 1'b0;
    pc_update   = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    illegal     = 1'b0;
    case (state_r)
      S_FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every architectural write regardless of where the FSM was.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign IRWrite  = ~reset & ir_write_s;
  assign MemWrite = ~reset & mem_write_s;
  assign RegWrite = ~reset & reg_write_s;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (trap on / trap off) share all inputs.
// Each cycle's stimulus and expected output vectors are queued together, then replayed and compared.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic       PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0, illegal0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0;
  logic [2:0] ALUControl0;
  logic [3:0] state0;

  always #5 clk = ~clk;

  multicycle_controller #(.ENABLE_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  multicycle_controller #(.ENABLE_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
    .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUControl(ALUControl0),
    .ImmSrc(ImmSrc0), .RegWrite(RegWrite0), .illegal(illegal0), .state(state0)
  );

  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal}
  logic [20:0] obs, obs0;
  assign obs  = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
  assign obs0 = {state0, PCWrite0, AdrSrc0, MemWrite0, IRWrite0, RegWrite0, ResultSrc0,
                 ALUSrcA0, ALUSrcB0, ALUControl0, ImmSrc0, illegal0};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
  } stim_t;

  stim_t       stim_q[$];
  logic [20:0] exp_q[$];
  logic [20:0] exp0_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [20:0] ov(logic [3:0] st, logic pcw, logic adr, logic mw, logic irw,
                                     logic rw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [1:0] imm, logic ill);
    return {st, pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic void q2(stim_t s, logic [20:0] e, logic [20:0] e0);
    stim_q.push_back(s);
    exp_q.push_back(e);
    exp0_q.push_back(e0);
  endfunction

  function automatic void q1(stim_t s, logic [20:0] e);
    q2(s, e, e);
  endfunction

  function automatic stim_t mk(logic rst, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    stim_t s;
    s.rst = rst; s.op = o; s.f3 = f3; s.f7 = f7; s.z = z;
    return s;
  endfunction

  task automatic test_reset();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    q1(mk(1, OP_R, 3'b000, 1, 0), ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(1, OP_R, 3'b000, 1, 0), ov(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0));
    q1(mk(1, OP_R, 3'b000, 1, 0), ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL reset cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_rtype_sub();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 1, 0), ov(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    q1(mk(0, OP_I, 3'b000, 1, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_I, 3'b000, 1, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(0, OP_I, 3'b000, 1, 0), ov(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(0, OP_I, 3'b000, 1, 0), ov(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rsub cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL rsub cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_alu_ops();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    // {funct3, funct7b5, expected ALUControl in EXECUTER}
    logic [6:0] tbl [5] = '{{3'b111, 1'b0, 3'b010}, {3'b110, 1'b1, 3'b011},
                            {3'b010, 1'b0, 3'b101}, {3'b000, 1'b0, 3'b000},
                            {3'b001, 1'b1, 3'b000}};
    for (int i = 0; i < 5; i++) begin
      q1(mk(0, OP_R, tbl[i][6:4], tbl[i][3], 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
      q1(mk(0, OP_R, tbl[i][6:4], tbl[i][3], 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
      q1(mk(0, OP_R, tbl[i][6:4], tbl[i][3], 0), ov(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, tbl[i][2:0], 2'b00, 0));
      q1(mk(0, OP_R, tbl[i][6:4], tbl[i][3], 0), ov(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL aluops cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL aluops cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_lw_sw();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    q1(mk(0, OP_LW, 3'b010, 0, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_LW, 3'b010, 0, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(0, OP_LW, 3'b010, 0, 0), ov(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    q1(mk(0, OP_LW, 3'b010, 0, 0), ov(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    q1(mk(0, OP_LW, 3'b010, 0, 0), ov(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    q1(mk(0, OP_SW, 3'b010, 0, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0));
    q1(mk(0, OP_SW, 3'b010, 0, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0));
    q1(mk(0, OP_SW, 3'b010, 0, 0), ov(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    q1(mk(0, OP_SW, 3'b010, 0, 0), ov(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL lwsw cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL lwsw cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_beq();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    q1(mk(0, OP_BEQ, 3'b000, 0, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0));
    q1(mk(0, OP_BEQ, 3'b000, 0, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0));
    q1(mk(0, OP_BEQ, 3'b000, 0, 1), ov(9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    // zero high outside BEQ must not leak into PCWrite
    q1(mk(0, OP_BEQ, 3'b000, 0, 1), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10, 0));
    q1(mk(0, OP_BEQ, 3'b000, 0, 1), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0));
    q1(mk(0, OP_BEQ, 3'b000, 0, 0), ov(9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL beq cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL beq cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_jal();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    q1(mk(0, OP_JAL, 3'b000, 0, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11, 0));
    q1(mk(0, OP_JAL, 3'b000, 0, 0), ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11, 0));
    q1(mk(0, OP_JAL, 3'b000, 0, 0), ov(10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
    q1(mk(0, OP_JAL, 3'b000, 0, 0), ov(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL jal cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL jal cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_illegal();
    int n = 0;
    stim_t s;
    logic [20:0] e, e0;
    logic [20:0] fetch_v, decode_v, ill_v;
    fetch_v  = ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
    decode_v = ov(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0);
    ill_v    = ov(11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
    q1(mk(0, OP_BAD, 3'b000, 0, 1), fetch_v);
    q1(mk(0, OP_BAD, 3'b000, 0, 1), decode_v);
    // trap-off instance simply alternates FETCH/DECODE while the trapping one sits in ILLEGAL
    for (int i = 0; i < 10; i++)
      q2(mk(0, OP_BAD, 3'b000, 0, 1), ill_v, (i % 2 == 0) ? fetch_v : decode_v);
    q2(mk(1, OP_BAD, 3'b000, 0, 1), ill_v,
       ov(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 0, 0), ov(0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 0, 0), decode_v);
    q1(mk(0, OP_R, 3'b000, 0, 0), ov(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0));
    q1(mk(0, OP_R, 3'b000, 0, 0), ov(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      reset = s.rst; op = s.op; funct3 = s.f3; funct7b5 = s.f7; zero = s.z;
      @(negedge clk);
      e = exp_q.pop_front(); e0 = exp0_q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL illegal cyc%0d trap1 got=%b want=%b", n, obs, e); end
      total++;
      if (obs0 !== e0) begin bad++; $display("FAIL illegal cyc%0d trap0 got=%b want=%b", n, obs0, e0); end
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    reset = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype_sub();
    test_alu_ops();
    test_lw_sw();
    test_beq();
    test_jal();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RISC-V datapath. The datapath has a shared instruction/data memory, an instruction register (IR), OldPC/Data/ALUOut registers, and a 3-way ALU-source muxing scheme.
- Decodes op/funct fields from the IR and drives the write enables, mux selects, ALUControl and ImmSrc for each state.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal. Unknown opcodes trap.
- Replaces combinational single-cycle control when the datapath is built in multicycle form.

Parameters:
- ENABLE_TRAP, 1: 1 = unknown opcode enters ILLEGAL (sticky); 0 = unknown opcode returns to FETCH (acts as nop).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  IR[6:0].
- funct3  input  3  IR[14:12].
- funct7b5  input  1  IR[30].
- zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  IR and OldPC load enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  output  1  register file write enable.
- illegal  output  1  high while in ILLEGAL.
- state  output  4  current state, for debug.

Behaviour:
- Single 4-bit state register, updated on the rising clk edge. All outputs are combinational from state, op and funct fields, plus zero for PCWrite.
- Reset:
  - reset=1 at an edge forces state to FETCH (0), including mid-instruction or from ILLEGAL.
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 irrespective of state.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11. Codes 12-15 go to FETCH on the next edge with all enables 0.
- Default output values in every state: all enables 0, all selects 00, ALUOp 00.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - ILLEGAL: all enables 0, illegal=1.
- PCWrite = PCUpdate | (Branch & zero). zero is sampled combinationally in BEQ only.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - other -> ILLEGAL (ENABLE_TRAP=1) or FETCH (ENABLE_TRAP=0).
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - JAL -> ALUWB (writes PC+4 to rd).
  - BEQ -> FETCH.
  - ILLEGAL -> ILLEGAL until reset.
- Instruction latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- ALU decoder:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000 -> 001 if (funct7b5 & op[5]), else 000 (addi is never sub).
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - other -> 000.
  - ALUOp 11 -> 000.
- ImmSrc decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- op and funct inputs are valid from DECODE onward; their values during FETCH affect only ImmSrc and ALUControl, not transitions.

Test Plan:
- Reset: hold reset 2 cycles, with state forced to 6 beforehand -> state=0, all enables 0 during reset. After release, FETCH shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> states 0,1,6,8,0. In EXECUTER, ALUControl=001. In ALUWB, RegWrite=1 for exactly one cycle.
- lw then sw -> lw states 0,1,2,3,4 (MemWrite never 1, RegWrite only in state 4). sw states 0,1,2,5 with MemWrite=1 and AdrSrc=1 only in state 5, ImmSrc=01.
- beq with zero=1 -> PCWrite=1 in BEQ. With zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- jal (op=1101111) -> states 0,1,10,8. In JAL, PCWrite=1, ImmSrc=11. In ALUWB, RegWrite=1.
- op=1111111 with ENABLE_TRAP=1 -> state 11, illegal=1, held 10 cycles with all enables 0. reset -> state 0. With ENABLE_TRAP=0 -> DECODE then FETCH.
